// File: rtl/mem_controller.sv
// Multi-channel memory front end: each channel FSM claims one consumer's read or write,
// forwards it to memory and relays the response until the consumer releases its request.
module mem_controller #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_CONSUMERS-1:0]                    consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDRESS_WIDTH-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                    consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]    consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                    consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDRESS_WIDTH-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]    consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                    consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                     mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                     mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]     mem_read_data,
  output logic [NUM_CHANNELS-1:0]                     mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]  mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]     mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                     mem_write_ready
);
  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_WAITING,
    S_WRITE_WAITING,
    S_READ_RELAYING,
    S_WRITE_RELAYING
  } state_t;

  state_t                   r_state     [NUM_CHANNELS];
  state_t                   w_state_nxt [NUM_CHANNELS];
  logic [CW-1:0]            r_cons      [NUM_CHANNELS];
  logic [CW-1:0]            w_cons_nxt  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  w_claim, w_claim_rd, w_rd_done, w_wr_done, w_rd_rel, w_wr_rel;
  logic [NUM_CONSUMERS-1:0] r_serving, w_serving_nxt, w_wr_req;

  logic [NUM_CONSUMERS-1:0]                   r_rd_ready, r_wr_ready;
  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]   r_rd_data;
  logic [NUM_CHANNELS-1:0]                    r_m_rv, r_m_wv;
  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] r_m_ra, r_m_wa;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    r_m_wd;

  // With the write path removed, write requests are invisible to the claim logic.
  assign w_wr_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

  // Claims walk channels in index order against a running taken mask, so a consumer
  // is never claimed twice in one cycle. Releases only touch already-taken consumers.
  always_comb begin
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    taken         = r_serving;
    found         = 1'b0;
    w_serving_nxt = r_serving;
    w_claim       = '0;
    w_claim_rd    = '0;
    w_rd_done     = '0;
    w_wr_done     = '0;
    w_rd_rel      = '0;
    w_wr_rel      = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      w_state_nxt[ch] = r_state[ch];
      w_cons_nxt[ch]  = r_cons[ch];
      found           = 1'b0;
      case (r_state[ch])
        S_IDLE: begin
          for (int c = 0; c < NUM_CONSUMERS; c++) begin
            if (!found && !taken[c] && (consumer_read_valid[c] || w_wr_req[c])) begin
              found            = 1'b1;
              taken[c]         = 1'b1;
              w_serving_nxt[c] = 1'b1;
              w_claim[ch]      = 1'b1;
              w_claim_rd[ch]   = consumer_read_valid[c];
              w_cons_nxt[ch]   = CW'(c);
              w_state_nxt[ch]  = consumer_read_valid[c] ? S_READ_WAITING : S_WRITE_WAITING;
            end
          end
        end
        S_READ_WAITING: begin
          if (mem_read_ready[ch]) begin
            w_rd_done[ch]   = 1'b1;
            w_state_nxt[ch] = S_READ_RELAYING;
          end
        end
        S_WRITE_WAITING: begin
          if (mem_write_ready[ch]) begin
            w_wr_done[ch]   = 1'b1;
            w_state_nxt[ch] = S_WRITE_RELAYING;
          end
        end
        S_READ_RELAYING: begin
          if (!consumer_read_valid[r_cons[ch]]) begin
            w_rd_rel[ch]                 = 1'b1;
            w_serving_nxt[r_cons[ch]]    = 1'b0;
            w_state_nxt[ch]              = S_IDLE;
          end
        end
        S_WRITE_RELAYING: begin
          if (!consumer_write_valid[r_cons[ch]]) begin
            w_wr_rel[ch]                 = 1'b1;
            w_serving_nxt[r_cons[ch]]    = 1'b0;
            w_state_nxt[ch]              = S_IDLE;
          end
        end
        default: w_state_nxt[ch] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        r_state[ch] <= S_IDLE;
        r_cons[ch]  <= '0;
      end
      r_serving  <= '0;
      r_rd_ready <= '0;
      r_wr_ready <= '0;
      r_rd_data  <= '0;
      r_m_rv     <= '0;
      r_m_wv     <= '0;
      r_m_ra     <= '0;
      r_m_wa     <= '0;
      r_m_wd     <= '0;
    end else begin
      r_serving <= w_serving_nxt;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        r_state[ch] <= w_state_nxt[ch];
        r_cons[ch]  <= w_cons_nxt[ch];
        if (w_claim[ch] && w_claim_rd[ch]) begin
          r_m_rv[ch] <= 1'b1;
          r_m_ra[ch] <= consumer_read_address[w_cons_nxt[ch]];
        end
        if (w_claim[ch] && !w_claim_rd[ch]) begin
          r_m_wv[ch] <= 1'b1;
          r_m_wa[ch] <= consumer_write_address[w_cons_nxt[ch]];
          r_m_wd[ch] <= consumer_write_data[w_cons_nxt[ch]];
        end
        if (w_rd_done[ch]) begin
          r_m_rv[ch]             <= 1'b0;
          r_rd_ready[r_cons[ch]] <= 1'b1;
          r_rd_data[r_cons[ch]]  <= mem_read_data[ch];
        end
        if (w_wr_done[ch]) begin
          r_m_wv[ch]             <= 1'b0;
          r_wr_ready[r_cons[ch]] <= 1'b1;
        end
        if (w_rd_rel[ch]) r_rd_ready[r_cons[ch]] <= 1'b0;
        if (w_wr_rel[ch]) r_wr_ready[r_cons[ch]] <= 1'b0;
      end
    end
  end

  assign consumer_read_ready  = r_rd_ready;
  assign consumer_read_data   = r_rd_data;
  assign mem_read_valid       = r_m_rv;
  assign mem_read_address     = r_m_ra;
  assign consumer_write_ready = (WRITE_ENABLE != 0) ? r_wr_ready : '0;
  assign mem_write_valid      = (WRITE_ENABLE != 0) ? r_m_wv : '0;
  assign mem_write_address    = (WRITE_ENABLE != 0) ? r_m_wa : '0;
  assign mem_write_data       = (WRITE_ENABLE != 0) ? r_m_wd : '0;

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: directed scenarios plus randomized consumers/memory
// checked through per-consumer expectation queues and a memory write log.
module tb_mem_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_f(input logic [7:0] a);
    return {a ^ 8'hC3, ~a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT A: 2 channels, write path present ----------------
  logic             rst_a;
  logic [3:0]       a_rd_valid, a_rd_ready, a_wr_valid, a_wr_ready;
  logic [3:0][7:0]  a_rd_addr, a_wr_addr;
  logic [3:0][15:0] a_rd_data, a_wr_data;
  logic [1:0]       a_m_rv, a_m_rr, a_m_wv, a_m_wr;
  logic [1:0][7:0]  a_m_ra, a_m_wa;
  logic [1:0][15:0] a_m_rd, a_m_wd;

  mem_controller #(.DATA_WIDTH(16), .ADDRESS_WIDTH(8), .NUM_CONSUMERS(4),
                   .NUM_CHANNELS(2), .WRITE_ENABLE(1)) u_a (
    .clk(clk), .reset(rst_a),
    .consumer_read_valid(a_rd_valid), .consumer_read_address(a_rd_addr),
    .consumer_read_ready(a_rd_ready), .consumer_read_data(a_rd_data),
    .consumer_write_valid(a_wr_valid), .consumer_write_address(a_wr_addr),
    .consumer_write_data(a_wr_data), .consumer_write_ready(a_wr_ready),
    .mem_read_valid(a_m_rv), .mem_read_address(a_m_ra),
    .mem_read_ready(a_m_rr), .mem_read_data(a_m_rd),
    .mem_write_valid(a_m_wv), .mem_write_address(a_m_wa),
    .mem_write_data(a_m_wd), .mem_write_ready(a_m_wr));

  // ---------------- DUT B: 1 channel, write path removed ----------------
  logic             rst_b, b_done;
  logic [3:0]       b_rd_valid, b_rd_ready, b_wr_valid, b_wr_ready;
  logic [3:0][7:0]  b_rd_addr, b_wr_addr;
  logic [3:0][15:0] b_rd_data, b_wr_data;
  logic [0:0]       b_m_rv, b_m_rr, b_m_wv, b_m_wr;
  logic [0:0][7:0]  b_m_ra, b_m_wa;
  logic [0:0][15:0] b_m_rd, b_m_wd;

  mem_controller #(.DATA_WIDTH(16), .ADDRESS_WIDTH(8), .NUM_CONSUMERS(4),
                   .NUM_CHANNELS(1), .WRITE_ENABLE(0)) u_b (
    .clk(clk), .reset(rst_b),
    .consumer_read_valid(b_rd_valid), .consumer_read_address(b_rd_addr),
    .consumer_read_ready(b_rd_ready), .consumer_read_data(b_rd_data),
    .consumer_write_valid(b_wr_valid), .consumer_write_address(b_wr_addr),
    .consumer_write_data(b_wr_data), .consumer_write_ready(b_wr_ready),
    .mem_read_valid(b_m_rv), .mem_read_address(b_m_ra),
    .mem_read_ready(b_m_rr), .mem_read_data(b_m_rd),
    .mem_write_valid(b_m_wv), .mem_write_address(b_m_wa),
    .mem_write_data(b_m_wd), .mem_write_ready(b_m_wr));

  // ---------------- scoreboard for the random phase of DUT A ----------------
  typedef struct packed {
    logic        is_wr;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q [4][$];
  logic [23:0] wlog [$];
  logic        sb_on = 1'b0;
  logic [3:0]  prev_rd = '0, prev_wr = '0;

  always @(negedge clk) begin
    exp_t e;
    logic found;
    if (sb_on) begin
      for (int c = 0; c < 4; c++) begin
        if (a_rd_ready[c] && !prev_rd[c]) begin
          check("sb_rd_pending", exp_q[c].size() != 0, 1);
          if (exp_q[c].size() != 0) begin
            e = exp_q[c].pop_front();
            check("sb_rd_kind", e.is_wr, 0);
            check("sb_rd_data", a_rd_data[c], e.data);
          end
        end
        if (a_wr_ready[c] && !prev_wr[c]) begin
          check("sb_wr_pending", exp_q[c].size() != 0, 1);
          if (exp_q[c].size() != 0) begin
            e = exp_q[c].pop_front();
            check("sb_wr_kind", e.is_wr, 1);
            found = 1'b0;
            for (int i = 0; i < wlog.size(); i++) begin
              if (!found && wlog[i] == {e.addr, e.data}) begin
                found = 1'b1;
                wlog.delete(i);
              end
            end
            check("sb_wr_reached_mem", found, 1);
          end
        end
      end
    end
    prev_rd = a_rd_ready;
    prev_wr = a_wr_ready;
  end

  task automatic responder(input int ch);
    forever begin
      @(negedge clk);
      if (a_m_rv[ch]) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        a_m_rd[ch] = mem_f(a_m_ra[ch]);
        a_m_rr[ch] = 1'b1;
        @(posedge clk); #1;
        a_m_rr[ch] = 1'b0;
      end else if (a_m_wv[ch]) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        wlog.push_back({a_m_wa[ch], a_m_wd[ch]});
        a_m_wr[ch] = 1'b1;
        @(posedge clk); #1;
        a_m_wr[ch] = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        a_m_rd[ch] = 16'($urandom);
        a_m_rr[ch] = 1'b1;
        a_m_wr[ch] = 1'b1;
        @(posedge clk); #1;
        a_m_rr[ch] = 1'b0;
        a_m_wr[ch] = 1'b0;
      end
    end
  endtask

  task automatic agent(input int c, input int n);
    exp_t e;
    int   cnt;
    logic rd, rdy;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      rd      = 1'($urandom_range(0, 1));
      e.is_wr = !rd;
      e.addr  = 8'($urandom);
      e.data  = 16'($urandom);
      if (rd) begin
        e.data        = mem_f(e.addr);
        a_rd_addr[c]  = e.addr;
        a_rd_valid[c] = 1'b1;
      end else begin
        a_wr_addr[c]  = e.addr;
        a_wr_data[c]  = e.data;
        a_wr_valid[c] = 1'b1;
      end
      exp_q[c].push_back(e);
      cnt = 0;
      rdy = 1'b0;
      while (!rdy && cnt < 400) begin
        @(negedge clk);
        cnt++;
        rdy = rd ? a_rd_ready[c] : a_wr_ready[c];
      end
      check("agent_ready_seen", rdy, 1);
      if (!rdy) return;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #1;
      if (rd) a_rd_valid[c] = 1'b0;
      else    a_wr_valid[c] = 1'b0;
      step();
      check("agent_ready_release", rd ? a_rd_ready[c] : a_wr_ready[c], 0);
    end
  endtask

  // ---------------- DUT A directed + random ----------------
  initial begin
    int cnt;
    rst_a = 1'b1;
    a_rd_valid = '0; a_wr_valid = '0; a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0;
    a_m_rr = '0; a_m_rd = '0; a_m_wr = '0;
    repeat (3) step();
    rst_a = 1'b0;
    check("rst_rd_ready", a_rd_ready, 0);
    check("rst_wr_ready", a_wr_ready, 0);
    check("rst_m_rv", a_m_rv, 0);
    check("rst_m_wv", a_m_wv, 0);
    check("rst_m_ra", a_m_ra, 0);
    check("rst_m_wa_wd", {a_m_wa, a_m_wd}, 0);
    check("rst_rd_data", a_rd_data, 0);

    // single read, memory answering immediately
    a_rd_addr[0] = 8'h12; a_rd_valid[0] = 1'b1;
    step();
    check("rd_claim_valid", a_m_rv, 2'b01);
    check("rd_claim_addr", a_m_ra[0], 8'h12);
    check("rd_not_ready_yet", a_rd_ready, 0);
    a_m_rr[0] = 1'b1; a_m_rd[0] = 16'hABCD;
    step();
    a_m_rr[0] = 1'b0;
    check("rd_ready", a_rd_ready, 4'b0001);
    check("rd_data", a_rd_data[0], 16'hABCD);
    check("rd_mem_valid_drop", a_m_rv, 0);
    step();
    check("rd_ready_hold", a_rd_ready, 4'b0001);
    a_rd_valid[0] = 1'b0;
    step();
    check("rd_ready_clear", a_rd_ready, 0);

    // single write from consumer 2
    a_wr_addr[2] = 8'h34; a_wr_data[2] = 16'h5555; a_wr_valid[2] = 1'b1;
    step();
    check("wr_claim_valid", a_m_wv, 2'b01);
    check("wr_claim_addr", a_m_wa[0], 8'h34);
    check("wr_claim_data", a_m_wd[0], 16'h5555);
    a_m_wr[0] = 1'b1;
    step();
    a_m_wr[0] = 1'b0;
    check("wr_ready", a_wr_ready, 4'b0100);
    check("wr_mem_valid_drop", a_m_wv, 0);
    a_wr_valid[2] = 1'b0;
    step();
    check("wr_ready_clear", a_wr_ready, 0);

    // two channels serve consumers 1 and 3 in the same cycle
    a_rd_addr[1] = 8'h21; a_rd_addr[3] = 8'h43; a_rd_valid = 4'b1010;
    step();
    check("conc_valid", a_m_rv, 2'b11);
    check("conc_addr_ch0", a_m_ra[0], 8'h21);
    check("conc_addr_ch1", a_m_ra[1], 8'h43);
    a_m_rr = 2'b11; a_m_rd[0] = 16'h1111; a_m_rd[1] = 16'h3333;
    step();
    a_m_rr = 2'b00;
    check("conc_ready", a_rd_ready, 4'b1010);
    check("conc_data", {a_rd_data[3], a_rd_data[1]}, 32'h3333_1111);
    a_rd_valid = '0;
    step();
    check("conc_clear", a_rd_ready, 0);

    // read wins over write for one consumer; write follows after the read releases
    a_rd_addr[1] = 8'h55; a_wr_addr[1] = 8'h66; a_wr_data[1] = 16'h7777;
    a_rd_valid[1] = 1'b1; a_wr_valid[1] = 1'b1;
    step();
    check("prec_read_first", {a_m_rv, a_m_wv}, 4'b0100);
    a_m_rr[0] = 1'b1; a_m_rd[0] = 16'h5A5A;
    step();
    a_m_rr[0] = 1'b0;
    check("prec_rd_ready", a_rd_ready, 4'b0010);
    a_rd_valid[1] = 1'b0;
    step();
    check("prec_no_write_yet", a_m_wv, 0);
    step();
    check("prec_write_claim", a_m_wv, 2'b01);
    check("prec_write_addr", a_m_wa[0], 8'h66);
    a_m_wr[0] = 1'b1;
    step();
    a_m_wr[0] = 1'b0;
    check("prec_wr_ready", a_wr_ready, 4'b0010);
    a_wr_valid[1] = 1'b0;
    step();

    // reset while a read is waiting on memory
    a_rd_addr[0] = 8'h77; a_rd_valid[0] = 1'b1;
    step();
    check("abort_claim", a_m_rv, 2'b01);
    rst_a = 1'b1; a_rd_valid[0] = 1'b0;
    step();
    rst_a = 1'b0;
    check("abort_m_rv", a_m_rv, 0);
    check("abort_m_ra", a_m_ra, 0);
    check("abort_rd_data", a_rd_data, 0);
    a_m_rr[0] = 1'b1; a_m_rd[0] = 16'hBEEF;
    step();
    a_m_rr[0] = 1'b0;
    step();
    check("abort_no_ready", a_rd_ready, 0);
    a_rd_addr[0] = 8'h88; a_rd_valid[0] = 1'b1;
    step();
    check("fresh_addr", a_m_ra[0], 8'h88);
    a_m_rr[0] = 1'b1; a_m_rd[0] = 16'h0F0F;
    step();
    a_m_rr[0] = 1'b0;
    check("fresh_ready", {a_rd_ready, a_rd_data[0]}, {4'b0001, 16'h0F0F});
    a_rd_valid[0] = 1'b0;
    step();

    // randomized traffic
    sb_on = 1'b1;
    fork
      responder(0);
      responder(1);
    join_none
    fork
      agent(0, 25);
      agent(1, 25);
      agent(2, 25);
      agent(3, 25);
    join
    repeat (4) step();
    for (int c = 0; c < 4; c++) check("sb_drained", exp_q[c].size(), 0);

    cnt = 0;
    while (!b_done && cnt < 2000) begin
      step();
      cnt++;
    end
    check("b_finished", b_done, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- DUT B: contention order and disabled write path ----------------
  initial begin
    logic [3:0] pending;
    int         exp_c, cnt;
    b_done = 1'b0;
    rst_b = 1'b1;
    b_rd_valid = '0; b_wr_valid = '0; b_m_rr = '0; b_m_rd = '0; b_m_wr = 1'b1;
    for (int c = 0; c < 4; c++) begin
      b_rd_addr[c] = 8'h10 + 8'(c);
      b_wr_addr[c] = 8'hE0 + 8'(c);
      b_wr_data[c] = 16'h9000 + 16'(c);
    end
    repeat (2) step();
    rst_b = 1'b0;
    b_rd_valid = 4'hF;
    b_wr_valid = 4'hF;
    pending = 4'hF;
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      while (!b_m_rv[0] && cnt < 20) begin
        step();
        cnt++;
      end
      check("b_req_seen", b_m_rv[0], 1);
      exp_c = 0;
      for (int i = 3; i >= 0; i--) if (pending[i]) exp_c = i;
      check("b_order_addr", b_m_ra[0], 8'h10 + 8'(exp_c));
      check("b_no_mem_write", b_m_wv, 0);
      b_m_rr[0] = 1'b1;
      b_m_rd[0] = mem_f(b_m_ra[0]);
      step();
      b_m_rr[0] = 1'b0;
      check("b_one_outstanding", b_m_rv, 0);
      check("b_order_ready", b_rd_ready, 4'b0001 << exp_c);
      check("b_data", b_rd_data[exp_c], mem_f(8'h10 + 8'(exp_c)));
      check("b_no_wr_ready", b_wr_ready, 0);
      b_rd_valid[exp_c] = 1'b0;
      pending[exp_c] = 1'b0;
      step();
      check("b_release", b_rd_ready, 0);
    end
    repeat (5) begin
      step();
      check("b_idle_no_mem_write", {b_m_wv, b_m_wa, b_m_wd}, 0);
      check("b_idle_no_wr_ready", b_wr_ready, 0);
    end
    b_wr_valid = '0;
    b_done = 1'b1;
  end
endmodule
